// File: rtl/aes128_input_packer.sv
// Packs 32-bit words into 128-bit key/plaintext blocks for the AES-128 core.
// Holds the current key and issues {plaintext, key} pairs via a one-deep slot.
module aes128_input_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_is_key,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [127:0]     out_plaintext,
  output logic [127:0]     out_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             key_loaded,
  output logic             err_seq,
  output logic [CNT_W-1:0] blk_count
);

  typedef enum logic [1:0] {
    IDLE,
    FILL_PT,
    FILL_KEY
  } state_t;

  state_t           r_state;
  logic [1:0]       r_word_cnt;
  logic [127:0]     r_asm;
  logic [127:0]     r_key;
  logic [127:0]     r_out_pt;
  logic [127:0]     r_out_key;
  logic             r_out_valid;
  logic             r_key_loaded;
  logic             r_err;
  logic [CNT_W-1:0] r_blk_cnt;

  logic             w_acc;
  logic             w_busy;
  logic             w_mis;
  logic             w_last;
  logic             w_pt_done;
  logic             w_key_done;
  logic             w_drain;
  logic [6:0]       w_lo;
  logic [127:0]     w_blk;

  assign in_ready = !(r_state == FILL_PT && r_word_cnt == 2'd3 &&
                      !in_is_key && r_out_valid && !out_ready);

  assign w_acc      = in_valid && in_ready;
  assign w_busy     = (r_state != IDLE);
  assign w_mis      = w_acc && w_busy &&
                      (in_is_key != (r_state == FILL_KEY));
  assign w_last     = w_acc && w_busy && !w_mis && (r_word_cnt == 2'd3);
  assign w_pt_done  = w_last && !in_is_key;
  assign w_key_done = w_last && in_is_key;
  assign w_drain    = r_out_valid && out_ready;
  // slot k occupies bits [127-32k -: 32]; (3-k) == ~k for 2 bits
  assign w_lo       = {~r_word_cnt, 5'd0};
  assign w_blk      = {r_asm[127:32], in_data};

  assign out_plaintext = r_out_pt;
  assign out_key       = r_out_key;
  assign out_valid     = r_out_valid;
  assign key_loaded    = r_key_loaded;
  assign err_seq       = r_err;
  assign blk_count     = r_blk_cnt;

  // group FSM: state, word counter and assembly register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_word_cnt <= 2'd0;
      r_asm      <= '0;
    end else if (w_acc) begin
      if (!w_busy || w_mis) begin
        r_state    <= in_is_key ? FILL_KEY : FILL_PT;
        r_word_cnt <= 2'd1;
        r_asm      <= {in_data, 96'd0};
      end else begin
        r_asm[w_lo +: 32] <= in_data;
        if (r_word_cnt == 2'd3) begin
          r_state    <= IDLE;
          r_word_cnt <= 2'd0;
        end else begin
          r_word_cnt <= r_word_cnt + 2'd1;
        end
      end
    end
  end

  // key register and loaded flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key        <= '0;
      r_key_loaded <= 1'b0;
    end else if (w_key_done) begin
      r_key        <= w_blk;
      r_key_loaded <= 1'b1;
    end
  end

  // output slot: reload on completion, else clear on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_pt    <= '0;
      r_out_key   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_pt_done && r_key_loaded) begin
      r_out_pt    <= w_blk;
      r_out_key   <= r_key;
      r_out_valid <= 1'b1;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  // error pulse and issued-block counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_blk_cnt <= '0;
    end else begin
      r_err <= w_mis || (w_pt_done && !r_key_loaded);
      if (w_drain)
        r_blk_cnt <= r_blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
